// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decode opcode interface: one 32-bit instruction per valid/ready handshake.
// Fetch side (master) drives valid, instruction, opcode and PC; decode side (slave) drives ready.
// Payload must stay stable while if_valid is high and if_ready is low.
interface instr_fetch_unit_if #(
  parameter int PC_W = 64
);
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [10:0]     if_opcode;
  logic [PC_W-1:0] if_pc;

  modport master (
    output if_valid,
    output if_instr,
    output if_opcode,
    output if_pc,
    input  if_ready
  );

  modport slave (
    input  if_valid,
    input  if_instr,
    input  if_opcode,
    input  if_pc,
    output if_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// LEGv8 fetch stage: PC plus word-addressed imem, with CBZ redirect and a sticky halt on a bad fetch PC.
// Latency: one cycle from PC to registered if_* outputs; a redirect target appears two cycles after br_taken.
// Backpressure: if_valid && !if_ready freezes pc and all if_* outputs. Optional macro IF_PREDECODE_EN adds if_class.
module instr_fetch_unit #(
  parameter int IMEM_DEPTH = 64,
  parameter int PC_W       = 64,
  parameter int AW         = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                imem_we,
  input  logic [AW-1:0]       imem_waddr,
  input  logic [31:0]         imem_wdata,
  input  logic                br_taken,
  input  logic [PC_W-1:0]     br_pc,
  input  logic [18:0]         br_off,
  instr_fetch_unit_if.master  ifc,
`ifdef IF_PREDECODE_EN
  output logic [1:0]          if_class,
`endif
  output logic                fault
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  localparam logic [PC_W-1:0] PC_LIMIT = PC_W'(IMEM_DEPTH * 4);

  logic [31:0]     imem [IMEM_DEPTH];

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] ifpc_q, ifpc_d;

  logic            fetch_slot;
  logic            pc_bad;
  logic            do_redirect;
  logic            do_fetch;
  logic [31:0]     fetch_word;
  logic [PC_W-1:0] br_target;

  // A new fetch may issue when the output register is empty or being drained this cycle.
  assign fetch_slot = !valid_q || ifc.if_ready;
  // Past the end of imem or not word-aligned: this fetch must never issue.
  assign pc_bad     = (pc_q >= PC_LIMIT) || (pc_q[1:0] != 2'b00);
  // Combinational read sees the array before this edge's write lands (old data on collision).
  assign fetch_word = imem[pc_q[AW+1:2]];
  // imm19 is a signed word offset; the sum wraps modulo 2^PC_W.
  assign br_target  = br_pc + {{(PC_W-21){br_off[18]}}, br_off, 2'b00};

`ifdef IF_PREDECODE_EN
  logic [1:0] class_q, class_d;

  function automatic logic [1:0] classify(input logic [10:0] op);
    logic [1:0] c;
    c = 2'b00;
    if (op[10] && (op[7:4] == 4'b0101) && (op[2:0] == 3'b000)) c = 2'b01;
    else if (op[10:3] == 8'b11111000)                          c = 2'b10;
    else if (op[10:3] == 8'b10110100)                          c = 2'b11;
    return c;
  endfunction
`endif

  // Instruction memory load port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= '0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ifpc_q  <= '0;
`ifdef IF_PREDECODE_EN
      class_q <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
`ifdef IF_PREDECODE_EN
      class_q <= class_d;
`endif
    end
  end

  // Next state: halt only when a fetch would actually issue from a bad PC; HALT is left only by reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (!br_taken && fetch_slot && pc_bad) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  // Control outputs of the FSM: redirect beats fetch, HALT ignores both.
  always_comb begin
    do_redirect = (state_q == RUN) && br_taken;
    do_fetch    = (state_q == RUN) && !br_taken && fetch_slot && !pc_bad;
    fault       = (state_q == HALT);
  end

  // Datapath next values: squash on redirect, load on fetch, otherwise hold.
  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
`ifdef IF_PREDECODE_EN
    class_d = class_q;
`endif
    if (do_redirect) begin
      pc_d    = br_target;
      valid_d = 1'b0;
    end else if (do_fetch) begin
      instr_d = fetch_word;
      ifpc_d  = pc_q;
      valid_d = 1'b1;
      pc_d    = pc_q + PC_W'(4);
`ifdef IF_PREDECODE_EN
      class_d = classify(fetch_word[31:21]);
`endif
    end else if (state_d == HALT) begin
      valid_d = 1'b0;
    end
  end

  assign ifc.if_valid  = valid_q;
  assign ifc.if_instr  = instr_q;
  assign ifc.if_opcode = instr_q[31:21];
  assign ifc.if_pc     = ifpc_q;
`ifdef IF_PREDECODE_EN
  assign if_class      = class_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, stall, redirect, end-of-imem halt,
// reset during stall and same-edge write/fetch collision. Expected values are hand-computed.
// Inputs driven 1 time unit after the rising edge; outputs checked at the same point.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_we = 1'b0;
  logic [5:0]  imem_waddr = '0;
  logic [31:0] imem_wdata = '0;
  logic        br_taken = 1'b0;
  logic [63:0] br_pc = '0;
  logic [18:0] br_off = '0;
  logic        fault;
`ifdef IF_PREDECODE_EN
  logic [1:0]  if_class;
`endif

  int n_vec = 0;
  int n_bad = 0;

  instr_fetch_unit_if #(.PC_W(64)) ifc ();

  instr_fetch_unit #(.IMEM_DEPTH(64), .PC_W(64), .AW(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .br_taken   (br_taken),
    .br_pc      (br_pc),
    .br_off     (br_off),
    .ifc        (ifc.master),
`ifdef IF_PREDECODE_EN
    .if_class   (if_class),
`endif
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [5:0] idx, input logic [31:0] word);
    imem_we    = 1'b1;
    imem_waddr = idx;
    imem_wdata = word;
    tick();
    imem_we    = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [63:0] pc, input logic [31:0] instr);
    chk({tag, ".valid"},  {63'd0, ifc.if_valid}, 64'd1);
    chk({tag, ".pc"},     ifc.if_pc, pc);
    chk({tag, ".instr"},  {32'd0, ifc.if_instr}, {32'd0, instr});
    chk({tag, ".opcode"}, {53'd0, ifc.if_opcode}, {53'd0, instr[31:21]});
  endtask

  initial begin
    ifc.if_ready = 1'b0;

    // imem load while held in reset
    load(6'd0,  32'h8B02_0020);
    load(6'd1,  32'hF840_0041);
    load(6'd2,  32'hF800_0062);
    load(6'd3,  32'hB400_0043);
    load(6'd62, 32'h9100_0421);
    load(6'd63, 32'hCB02_0020);

    chk("rst.valid",  {63'd0, ifc.if_valid}, 64'd0);
    chk("rst.pc",     ifc.if_pc, 64'd0);
    chk("rst.instr",  {32'd0, ifc.if_instr}, 64'd0);
    chk("rst.opcode", {53'd0, ifc.if_opcode}, 64'd0);
    chk("rst.fault",  {63'd0, fault}, 64'd0);

    // T1 sequential fetch
    rst = 1'b0;
    ifc.if_ready = 1'b1;
    tick(); chk_out("t1.0", 64'd0, 32'h8B02_0020);
    chk("t1.op0", {53'd0, ifc.if_opcode}, 64'h458);
`ifdef IF_PREDECODE_EN
    chk("t1.cls0", {62'd0, if_class}, 64'd1);
`endif
    tick(); chk_out("t1.4", 64'd4, 32'hF840_0041);
    chk("t1.op1", {53'd0, ifc.if_opcode}, 64'h7C2);
`ifdef IF_PREDECODE_EN
    chk("t1.cls1", {62'd0, if_class}, 64'd2);
`endif
    tick(); chk_out("t1.8", 64'd8, 32'hF800_0062);
    chk("t1.op2", {53'd0, ifc.if_opcode}, 64'h7C0);
`ifdef IF_PREDECODE_EN
    chk("t1.cls2", {62'd0, if_class}, 64'd2);
`endif
    tick(); chk_out("t1.12", 64'd12, 32'hB400_0043);
    chk("t1.op3", {53'd0, ifc.if_opcode}, 64'h5A0);
`ifdef IF_PREDECODE_EN
    chk("t1.cls3", {62'd0, if_class}, 64'd3);
`endif

    // T2 stall at pc 4
    rst = 1'b1;
    tick();
    chk("t2.rst.valid", {63'd0, ifc.if_valid}, 64'd0);
    rst = 1'b0;
    tick(); chk_out("t2.0", 64'd0, 32'h8B02_0020);
    tick(); chk_out("t2.4", 64'd4, 32'hF840_0041);
    ifc.if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_out("t2.hold", 64'd4, 32'hF840_0041);
    end
    ifc.if_ready = 1'b1;
    tick(); chk_out("t2.8", 64'd8, 32'hF800_0062);
    tick(); chk_out("t2.12", 64'd12, 32'hB400_0043);

    // T3 redirect: 12 + (-3 << 2) = 0
    br_taken = 1'b1; br_pc = 64'd12; br_off = 19'h7FFFD;
    tick();
    chk("t3.squash", {63'd0, ifc.if_valid}, 64'd0);
    br_taken = 1'b0;
    tick(); chk_out("t3.tgt", 64'd0, 32'h8B02_0020);

    // T4 end of imem: 248 and 252 issue, then halt
    br_taken = 1'b1; br_pc = 64'd248; br_off = 19'd0;
    tick();
    chk("t4.squash", {63'd0, ifc.if_valid}, 64'd0);
    br_taken = 1'b0;
    tick(); chk_out("t4.248", 64'd248, 32'h9100_0421);
    tick(); chk_out("t4.252", 64'd252, 32'hCB02_0020);
    tick();
    chk("t4.halt.valid", {63'd0, ifc.if_valid}, 64'd0);
    chk("t4.halt.fault", {63'd0, fault}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      br_taken     = i[0];
      br_pc        = 64'd0;
      ifc.if_ready = i[1];
      tick();
      chk("t4.held.valid", {63'd0, ifc.if_valid}, 64'd0);
      chk("t4.held.fault", {63'd0, fault}, 64'd1);
    end
    br_taken = 1'b0;
    ifc.if_ready = 1'b1;
    rst = 1'b1;
    tick();
    chk("t4.rst.fault", {63'd0, fault}, 64'd0);
    chk("t4.rst.valid", {63'd0, ifc.if_valid}, 64'd0);
    chk("t4.rst.pc",    ifc.if_pc, 64'd0);
    rst = 1'b0;
    tick(); chk_out("t4.restart", 64'd0, 32'h8B02_0020);

    // T5 reset during stall, then write/fetch collision on word 0
    tick(); chk_out("t5.4", 64'd4, 32'hF840_0041);
    ifc.if_ready = 1'b0;
    tick(); chk_out("t5.stall", 64'd4, 32'hF840_0041);
    rst = 1'b1;
    tick();
    chk("t5.rst.valid", {63'd0, ifc.if_valid}, 64'd0);
    chk("t5.rst.pc",    ifc.if_pc, 64'd0);
    rst = 1'b0;
    ifc.if_ready = 1'b1;
    imem_we = 1'b1; imem_waddr = 6'd0; imem_wdata = 32'hD65F_03C0;
    tick(); chk_out("t5.old", 64'd0, 32'h8B02_0020);
    imem_we = 1'b0;
    br_taken = 1'b1; br_pc = 64'd0; br_off = 19'd0;
    tick();
    chk("t5.squash", {63'd0, ifc.if_valid}, 64'd0);
    br_taken = 1'b0;
    tick(); chk_out("t5.new", 64'd0, 32'hD65F_03C0);
    chk("t5.opnew", {53'd0, ifc.if_opcode}, 64'h6B2);
`ifdef IF_PREDECODE_EN
    chk("t5.cls", {62'd0, if_class}, 64'd0);
`endif

    // misaligned redirect target halts on its fetch
    br_taken = 1'b1; br_pc = 64'd2; br_off = 19'd0;
    tick();
    chk("mis.squash", {63'd0, ifc.if_valid}, 64'd0);
    chk("mis.nofault", {63'd0, fault}, 64'd0);
    br_taken = 1'b0;
    tick();
    chk("mis.valid", {63'd0, ifc.if_valid}, 64'd0);
    chk("mis.fault", {63'd0, fault}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
